// File: rtl/wb_io_arbiter.sv
// Two-master Wishbone B4 arbiter in front of the IO bus decoder: round-robin grant held for the
// winner's whole CYC, plus a watchdog that ends hung strobes with ERR.
module wb_io_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic [31:0] wbm0_adr_i,
    input  logic [31:0] wbm0_dat_i,
    input  logic [3:0]  wbm0_sel_i,
    input  logic        wbm0_we_i,
    input  logic        wbm0_cyc_i,
    input  logic        wbm0_stb_i,
    input  logic [2:0]  wbm0_cti_i,
    input  logic [1:0]  wbm0_bte_i,
    output logic [31:0] wbm0_dat_o,
    output logic        wbm0_ack_o,
    output logic        wbm0_err_o,
    output logic        wbm0_rty_o,

    input  logic [31:0] wbm1_adr_i,
    input  logic [31:0] wbm1_dat_i,
    input  logic [3:0]  wbm1_sel_i,
    input  logic        wbm1_we_i,
    input  logic        wbm1_cyc_i,
    input  logic        wbm1_stb_i,
    input  logic [2:0]  wbm1_cti_i,
    input  logic [1:0]  wbm1_bte_i,
    output logic [31:0] wbm1_dat_o,
    output logic        wbm1_ack_o,
    output logic        wbm1_err_o,
    output logic        wbm1_rty_o,

    output logic [31:0] wbs_adr_o,
    output logic [31:0] wbs_dat_o,
    output logic [3:0]  wbs_sel_o,
    output logic        wbs_we_o,
    output logic        wbs_cyc_o,
    output logic        wbs_stb_o,
    output logic [2:0]  wbs_cti_o,
    output logic [1:0]  wbs_bte_o,
    input  logic [31:0] wbs_dat_i,
    input  logic        wbs_ack_i,
    input  logic        wbs_err_i,
    input  logic        wbs_rty_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    localparam bit WdogEn = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] FireAt = CNT_W'(WdogEn ? TIMEOUT - 1 : 0);

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    state_e           state;
    logic [1:0]       grant;
    logic             last;
    logic [CNT_W-1:0] wdog;

    logic busy;
    logic sel_cyc;
    logic sel_stb;
    logic slave_resp;
    logic fire;

    assign busy       = (state == StBusy);
    assign sel_cyc    = grant[1] ? wbm1_cyc_i : wbm0_cyc_i;
    assign sel_stb    = grant[1] ? wbm1_stb_i : wbm0_stb_i;
    assign slave_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
    // A slave response in the would-be firing cycle wins over the watchdog.
    assign fire       = WdogEn && busy && sel_cyc && sel_stb && !slave_resp && (wdog == FireAt);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= StIdle;
            grant <= 2'b00;
            last  <= 1'b1;
            wdog  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    wdog <= '0;
                    if (wbm0_cyc_i && (!wbm1_cyc_i || last)) begin
                        grant <= 2'b01;
                        state <= StBusy;
                    end else if (wbm1_cyc_i) begin
                        grant <= 2'b10;
                        state <= StBusy;
                    end
                end
                StBusy: begin
                    if (!sel_cyc) begin
                        state <= StIdle;
                        grant <= 2'b00;
                        last  <= grant[1];
                        wdog  <= '0;
                    end else if (WdogEn && sel_stb && !slave_resp && !fire) begin
                        wdog <= wdog + 1'b1;
                    end else begin
                        wdog <= '0;
                    end
                end
                default: begin
                    state <= StIdle;
                    grant <= 2'b00;
                    wdog  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        wbs_adr_o = grant[1] ? wbm1_adr_i : wbm0_adr_i;
        wbs_dat_o = grant[1] ? wbm1_dat_i : wbm0_dat_i;
        wbs_sel_o = grant[1] ? wbm1_sel_i : wbm0_sel_i;
        wbs_we_o  = grant[1] ? wbm1_we_i  : wbm0_we_i;
        wbs_cti_o = grant[1] ? wbm1_cti_i : wbm0_cti_i;
        wbs_bte_o = grant[1] ? wbm1_bte_i : wbm0_bte_i;
        wbs_cyc_o = busy && sel_cyc && !fire;
        wbs_stb_o = busy && sel_stb && !fire;
    end

    always_comb begin
        wbm0_dat_o = wbs_dat_i;
        wbm1_dat_o = wbs_dat_i;
        wbm0_ack_o = grant[0] & wbs_ack_i;
        wbm1_ack_o = grant[1] & wbs_ack_i;
        wbm0_err_o = grant[0] & (wbs_err_i | fire);
        wbm1_err_o = grant[1] & (wbs_err_i | fire);
        wbm0_rty_o = grant[0] & wbs_rty_i;
        wbm1_rty_o = grant[1] & wbs_rty_i;
    end

    assign grant_o   = grant;
    assign timeout_o = fire;

endmodule
